// File: rtl/shiftreg_deser.sv
// Serial-to-parallel deserializer: framed 4-bit words with Start marker, selectable bit order,
// Valid/Ack hand-off and sticky overrun. Define PARITY_CHECK_EN to append an even-parity bit.
module shiftreg_deser (
   input  logic       CLK,
   input  logic       Clear,
   input  logic       InS,
   input  logic       En,
   input  logic       Start,
   input  logic       RL,
   input  logic       Ack,
   output logic [3:0] Q,
   output logic       Valid,
   output logic       Busy,
   output logic       Overrun,
   output logic       PErr,
   output logic [1:0] dbg_state
);

   // Handshake: Valid rises with the completed word in Q and both hold until an edge with
   // Ack=1 in FULL; that edge clears Valid. Ack seen in any other state is ignored.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
`ifdef PARITY_CHECK_EN
      PAR  = 2'd2,
`endif
      FULL = 2'd3
   } state_t;

   state_t     state, state_d;
   logic [3:0] sr, sr_d, sr_nxt, q, q_d;
   logic [2:0] count, count_d;
   logic       valid, valid_d, overrun, overrun_d, rl_q, rl_d, begin_frame;
`ifdef PARITY_CHECK_EN
   logic       perr, perr_d;
`endif

   function automatic logic [3:0] shift_in(input logic [3:0] cur, input logic b, input logic rl);
      return rl ? {b, cur[3:1]} : {cur[2:0], b};
   endfunction

   always_ff @(posedge CLK or negedge Clear) begin
      if (!Clear) begin
         state   <= IDLE;
         sr      <= 4'b0000;
         q       <= 4'b0000;
         count   <= 3'd0;
         valid   <= 1'b0;
         overrun <= 1'b0;
         rl_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
         perr    <= 1'b0;
`endif
      end else begin
         state   <= state_d;
         sr      <= sr_d;
         q       <= q_d;
         count   <= count_d;
         valid   <= valid_d;
         overrun <= overrun_d;
         rl_q    <= rl_d;
`ifdef PARITY_CHECK_EN
         perr    <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d     = state;
      sr_d        = sr;
      q_d         = q;
      count_d     = count;
      valid_d     = valid;
      overrun_d   = overrun;
      rl_d        = rl_q;
      begin_frame = 1'b0;
`ifdef PARITY_CHECK_EN
      perr_d      = perr;
`endif
      sr_nxt = shift_in(sr, InS, rl_q);
      unique case (state)
         IDLE: begin
            if (En && Start) begin_frame = 1'b1;
         end
         RECV: begin
            if (En && Start) begin
               begin_frame = 1'b1;
            end else if (En) begin
               sr_d = sr_nxt;
               if (count == 3'd3) begin
`ifdef PARITY_CHECK_EN
                  state_d = PAR;
                  count_d = 3'd4;
`else
                  q_d     = sr_nxt;
                  valid_d = 1'b1;
                  state_d = FULL;
                  count_d = 3'd0;
`endif
               end else begin
                  count_d = count + 3'd1;
               end
            end
         end
`ifdef PARITY_CHECK_EN
         PAR: begin
            if (En && Start) begin
               begin_frame = 1'b1;
            end else if (En) begin
               q_d     = sr;
               perr_d  = (^sr) ^ InS;
               valid_d = 1'b1;
               state_d = FULL;
               count_d = 3'd0;
            end
         end
`endif
         FULL: begin
            // A Start arriving while the word is still unconsumed is lost unless Ack frees Q now.
            if (Ack) begin
               valid_d = 1'b0;
               state_d = IDLE;
               if (En && Start) begin_frame = 1'b1;
            end else if (En && Start) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (begin_frame) begin
         sr_d    = shift_in(4'b0000, InS, RL);
         count_d = 3'd1;
         rl_d    = RL;
         state_d = RECV;
      end
   end

   assign Q         = q;
   assign Valid     = valid;
   assign Overrun   = overrun;
   assign dbg_state = state;
`ifdef PARITY_CHECK_EN
   assign Busy = (state == RECV) || (state == PAR);
   assign PErr = perr;
`else
   assign Busy = (state == RECV);
   assign PErr = 1'b0;
`endif

endmodule

// File: doc/shiftreg_deser.md
SHIFTREG_DESER -- requirements
Module: shiftreg_deser

Interface
REQ-001 SHALL provide: CLK  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL provide: Clear  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: InS  input  1  serial data bit, sampled only when En=1.
REQ-004 SHALL provide: En  input  1  bit strobe; one serial bit per CLK edge with En=1.
REQ-005 SHALL provide: Start  input  1  marks the current En bit as first bit of a frame.
REQ-006 SHALL provide: RL  input  1  frame bit order, sampled with the Start bit and held for the frame.
REQ-007 SHALL provide: Ack  input  1  consumer accepts Q; clears Valid.
REQ-008 SHALL provide: Q  output  4  received parallel word.
REQ-009 SHALL provide: Valid  output  1  Q holds an unconsumed frame.
REQ-010 SHALL provide: Busy  output  1  frame reception in progress (state RECV or PAR).
REQ-011 SHALL provide: Overrun  output  1  sticky; frame start lost while Valid=1.
REQ-012 SHALL provide: PErr  output  1  parity error for the frame currently in Q.

Function
REQ-013 SHALL implement FSM states IDLE, RECV, PAR (only with macro), FULL.
REQ-014 IDLE: En&Start SHALL capture bit, set count=1, latch RL, go RECV; En without Start SHALL be ignored.
REQ-015 RECV: each En SHALL shift one bit and increment count; Start with En SHALL abort the partial frame and restart with count=1.
REQ-016 Latched RL=1 SHALL shift sr <= {InS, sr[3:1]} (first received bit ends in Q[0]); RL=0 SHALL shift sr <= {sr[2:0], InS} (first bit ends in Q[3]).
REQ-017 On the 4th data bit, Q SHALL load the completed word on the same edge, Valid SHALL rise on that edge, and FSM SHALL go FULL (or PAR with macro); latency 0 cycles after the final En edge.
REQ-018 FULL: Valid and Q SHALL hold until Ack=1; Ack SHALL clear Valid next edge and return to IDLE.
REQ-019 FULL with Ack and En&Start on the same edge: Valid SHALL clear, new frame SHALL start (count=1, RECV).
REQ-020 FULL with En&Start and no Ack: bit SHALL be dropped, Overrun SHALL set, Q unchanged.
REQ-021 Ack in any state other than FULL SHALL be ignored.
REQ-022 Overrun SHALL clear only via Clear.
REQ-023 count SHALL never exceed frame length; no wrap into a second frame without Start.

Reset
REQ-024 Clear=0 SHALL immediately force state IDLE, Q=0000, sr=0000, count=0, Valid=0, Busy=0, Overrun=0, PErr=0, independent of CLK.
REQ-025 Clear asserted mid-frame SHALL discard the partial frame; after release, reception SHALL resume only on a new Start.

Configuration
REQ-026 Macro PARITY_CHECK_EN defined: frame SHALL be 4 data bits plus 1 even-parity bit; after the 4th bit FSM SHALL enter PAR, the 5th En bit SHALL load Q and set PErr = (^sr) ^ InS, and Valid SHALL rise on that edge; Start during PAR SHALL restart the frame.
REQ-027 Macro undefined: PAR state and parity logic SHALL be absent, frame SHALL be 4 bits, PErr SHALL be constant 0.

Verification
REQ-028 Clear=0 at t=0 then release; RL=1, Start on first bit, InS=1,0,1,0 with En each cycle -> Q=0101, Valid=1 on 4th edge, Busy=0.
REQ-029 RL=0, same InS sequence 1,0,1,0 -> Q=1010, Valid=1; Ack one cycle -> Valid=0, state IDLE.
REQ-030 Valid=1, Q=0101, new Start frame without Ack -> Overrun=1, Q stays 0101; Ack then new frame 1,1,0,0 (RL=1) -> Q=0011, Overrun still 1.
REQ-031 Clear=0 after 2 bits of a frame -> all outputs 0 immediately; subsequent En without Start -> no change.
REQ-032 Start mid-frame after 2 bits, then 1,1,1,1 (RL=1) -> Q=1111, earlier bits discarded.
REQ-033 PARITY_CHECK_EN defined: bits 1,1,0,0 + parity 0 -> Q=0011, PErr=0; parity 1 -> PErr=1, Valid=1.
